// File: rtl/multicore_run_sequencer.sv
// rtl/multicore_run_sequencer.sv - job sequencer: UART load IMEM/DMEM, multicore execute, DMEM dump.
// Optional watchdog on EXECUTE enabled by defining WATCHDOG_EN.
module multicore_run_sequencer #(
  parameter int CORE_COUNT     = 4,
  parameter int TIME_WIDTH     = 26,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  startN,
  input  logic                  reload_imem,
  input  logic [CORE_COUNT-1:0] core_mask,
  input  logic                  imem_rx_done,
  input  logic                  dmem_rx_done,
  input  logic                  dmem_tx_done,
  input  logic [CORE_COUNT-1:0] core_done,
  output logic [2:0]            state,
  output logic                  imem_uart_sel,
  output logic                  dmem_uart_sel,
  output logic                  dmem_proc_sel,
  output logic                  proc_start,
  output logic                  dmem_tx_startN,
  output logic [TIME_WIDTH-1:0] exec_cycles,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_IMEM = 3'd1,
    S_LOAD_DMEM = 3'd2,
    S_EXECUTE   = 3'd3,
    S_TRANSMIT  = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q, sync3_q;
  logic [CORE_COUNT-1:0] mask_q, mask_d;
  logic [TIME_WIDTH-1:0] exec_q, exec_d;
  logic                  proc_start_q, proc_start_d;
  logic                  tx_startn_q, tx_startn_d;
  logic                  start_evt;
  logic                  all_done;
  logic                  exec_done;

  // Button synchroniser resets to the released level so reset never fakes a press.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= startN;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign start_evt = sync3_q & ~sync2_q;
  assign all_done  = &(core_done | ~mask_q);
  // First EXECUTE cycle may still see done levels left over from the previous run.
  assign exec_done = proc_start_q ? ~|mask_q : all_done;

`ifdef WATCHDOG_EN
  localparam logic [TIME_WIDTH-1:0] TIMEOUT_LAST = TIME_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    exec_d  = exec_q;
    case (state_q)
      S_IDLE:      if (start_evt)    state_d = S_LOAD_IMEM;
      S_LOAD_IMEM: if (imem_rx_done) state_d = S_LOAD_DMEM;
      S_LOAD_DMEM: begin
        if (dmem_rx_done) begin
          state_d = S_EXECUTE;
          mask_d  = core_mask;
          exec_d  = '0;
        end
      end
      S_EXECUTE: begin
        exec_d = (exec_q == {TIME_WIDTH{1'b1}}) ? exec_q : exec_q + 1'b1;
        if (exec_done) state_d = S_TRANSMIT;
`ifdef WATCHDOG_EN
        else if (exec_q == TIMEOUT_LAST) state_d = S_ERROR;
`endif
      end
      S_TRANSMIT:  if (dmem_tx_done) state_d = S_DONE;
      S_DONE:      if (start_evt)    state_d = reload_imem ? S_LOAD_IMEM : S_LOAD_DMEM;
      S_ERROR:     if (start_evt)    state_d = S_LOAD_IMEM;
      default:                       state_d = S_IDLE;
    endcase
    proc_start_d = (state_d == S_EXECUTE)  && (state_q != S_EXECUTE);
    tx_startn_d  = !((state_d == S_TRANSMIT) && (state_q != S_TRANSMIT));
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      exec_q       <= '0;
      proc_start_q <= 1'b0;
      tx_startn_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      exec_q       <= exec_d;
      proc_start_q <= proc_start_d;
      tx_startn_q  <= tx_startn_d;
    end
  end

  assign state          = state_q;
  assign imem_uart_sel  = (state_q == S_LOAD_IMEM);
  assign dmem_uart_sel  = (state_q == S_LOAD_DMEM) || (state_q == S_TRANSMIT);
  assign dmem_proc_sel  = (state_q == S_EXECUTE);
  assign proc_start     = proc_start_q;
  assign dmem_tx_startN = tx_startn_q;
  assign exec_cycles    = exec_q;
  assign busy           = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

`ifdef WATCHDOG_EN
  assign error = (state_q == S_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_multicore_run_sequencer.sv
// tb/tb_multicore_run_sequencer.sv - self-checking bench for multicore_run_sequencer.
module tb_multicore_run_sequencer;
  localparam int CC   = 4;
  localparam int TW   = 8;
  localparam int TMO  = 16;
  localparam int MAXE = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          startN = 1'b1;
  logic          reload_imem = 1'b0;
  logic [CC-1:0] core_mask = '0;
  logic [CC-1:0] core_done = '0;
  logic          imem_rx_done = 1'b0;
  logic          dmem_rx_done = 1'b0;
  logic          dmem_tx_done = 1'b0;
  logic [2:0]    state;
  logic          imem_uart_sel, dmem_uart_sel, dmem_proc_sel;
  logic          proc_start, dmem_tx_startN, busy, error;
  logic [TW-1:0] exec_cycles;

  multicore_run_sequencer #(.CORE_COUNT(CC), .TIME_WIDTH(TW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstN(rstN), .startN(startN), .reload_imem(reload_imem),
    .core_mask(core_mask), .imem_rx_done(imem_rx_done), .dmem_rx_done(dmem_rx_done),
    .dmem_tx_done(dmem_tx_done), .core_done(core_done), .state(state),
    .imem_uart_sel(imem_uart_sel), .dmem_uart_sel(dmem_uart_sel),
    .dmem_proc_sel(dmem_proc_sel), .proc_start(proc_start),
    .dmem_tx_startN(dmem_tx_startN), .exec_cycles(exec_cycles), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: job phase, cycles spent in the phase, cycle count, latched mask.
  int m_st, m_cyc, m_exec, m_mask;
  bit samp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_exec = 0; m_mask = 0;
    samp.delete();
    repeat (3) samp.push_back(1'b1);
  endtask

  task automatic model_edge();
    int  n, nst;
    bit  evt, fin;
    n   = samp.size();
    evt = (samp[n-3] == 1'b1) && (samp[n-2] == 1'b0);
    nst = m_st;
    case (m_st)
      0: if (evt) nst = 1;
      1: if (imem_rx_done) nst = 2;
      2: if (dmem_rx_done) begin nst = 3; m_mask = int'(core_mask); m_exec = 0; end
      3: begin
        fin = (m_mask == 0) || (m_cyc > 0 && ((int'(core_done) & m_mask) == m_mask));
`ifdef WATCHDOG_EN
        if (!fin && m_exec == TMO - 1) nst = 6;
`endif
        if (fin) nst = 4;
        m_exec = (m_exec < MAXE) ? m_exec + 1 : MAXE;
      end
      4: if (dmem_tx_done) nst = 5;
      5: if (evt) nst = reload_imem ? 1 : 2;
      6: if (evt) nst = 1;
      default: nst = 0;
    endcase
    m_cyc = (nst == m_st) ? m_cyc + 1 : 0;
    m_st  = nst;
    samp.push_back(startN);
    void'(samp.pop_front());
  endtask

  task automatic check_all();
    int exp_err;
    exp_err = 0;
`ifdef WATCHDOG_EN
    exp_err = (m_st == 6) ? 1 : 0;
`endif
    chk("state",          32'(state),          m_st);
    chk("imem_uart_sel",  32'(imem_uart_sel),  (m_st == 1) ? 1 : 0);
    chk("dmem_uart_sel",  32'(dmem_uart_sel),  (m_st == 2 || m_st == 4) ? 1 : 0);
    chk("dmem_proc_sel",  32'(dmem_proc_sel),  (m_st == 3) ? 1 : 0);
    chk("proc_start",     32'(proc_start),     (m_st == 3 && m_cyc == 0) ? 1 : 0);
    chk("dmem_tx_startN", 32'(dmem_tx_startN), (m_st == 4 && m_cyc == 0) ? 0 : 1);
    chk("exec_cycles",    32'(exec_cycles),    m_exec);
    chk("busy",           32'(busy),           (m_st == 0 || m_st == 5 || m_st == 6) ? 0 : 1);
    chk("error",          32'(error),          exp_err);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_sels"},  32'({imem_uart_sel, dmem_uart_sel, dmem_proc_sel}), 0);
    chk({tag, "_start"}, 32'(proc_start), 0);
    chk({tag, "_txn"},   32'(dmem_tx_startN), 1);
    chk({tag, "_exec"},  32'(exec_cycles), 0);
    chk({tag, "_busy"},  32'({busy, error}), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_imem(); imem_rx_done = 1'b1; step(); imem_rx_done = 1'b0; endtask
  task automatic pulse_dmem(); dmem_rx_done = 1'b1; step(); dmem_rx_done = 1'b0; endtask
  task automatic pulse_tx();   dmem_tx_done = 1'b1; step(); dmem_tx_done = 1'b0; endtask

  initial begin
    model_reset();
    #12;
    chk_reset("reset");
    rstN = 1'b1;
    step();

    // Full run with all four cores.
    startN = 1'b0;
    steps(2);
    chk("pre_event_idle", 32'(state), 0);
    step();
    chk("start_to_imem", 32'(state), 1);
    pulse_dmem();
    chk("spurious_rx_in_imem", 32'(state), 1);
    pulse_imem();
    chk("imem_to_dmem", 32'(state), 2);
    core_mask = 4'hF;
    pulse_dmem();
    chk("dmem_to_exec", 32'(state), 3);
    chk("proc_start_first", 32'(proc_start), 1);
    pulse_tx();
    chk("spurious_tx_in_exec", 32'(state), 3);
    chk("proc_start_second", 32'(proc_start), 0);
    steps(98);
    core_done = 4'hF;
    step();
    chk("exec_to_tx", 32'(state), 4);
    chk("exec_100", 32'(exec_cycles), 100);
    chk("tx_start_low", 32'(dmem_tx_startN), 0);
    step();
    chk("tx_start_one_cycle", 32'(dmem_tx_startN), 1);
    pulse_tx();
    chk("tx_to_done", 32'(state), 5);
    chk("done_not_busy", 32'(busy), 0);
    steps(4);
    chk("held_button_single_event", 32'(state), 5);
    startN = 1'b1;
    steps(3);

    // Rerun without IMEM reload, partial mask, stale done levels still high.
    reload_imem = 1'b0;
    core_mask   = 4'b0101;
    startN      = 1'b0;
    steps(3);
    chk("rerun_keep_imem", 32'(state), 2);
    startN = 1'b1;
    pulse_dmem();
    chk("rerun_exec", 32'(state), 3);
    chk("rerun_exec_cleared", 32'(exec_cycles), 0);
    core_mask = 4'hF;
    step();
    chk("stale_done_ignored", 32'(state), 3);
    core_done = 4'b0001;
    steps(5);
    chk("partial_not_done", 32'(state), 3);
    core_done = 4'b0101;
    step();
    chk("partial_done", 32'(state), 4);
    chk("partial_exec", 32'(exec_cycles), 7);
    pulse_tx();

    // Empty mask: one EXECUTE cycle.
    reload_imem = 1'b1;
    core_mask   = '0;
    startN      = 1'b0;
    steps(3);
    chk("rerun_reload_imem", 32'(state), 1);
    startN = 1'b1;
    pulse_imem();
    pulse_dmem();
    step();
    chk("empty_mask_tx", 32'(state), 4);
    chk("empty_mask_exec", 32'(exec_cycles), 1);
    pulse_tx();

    // Saturating counter, then reset in the middle of EXECUTE.
    startN = 1'b0;
    steps(3);
    startN    = 1'b1;
    core_done = '0;
    core_mask = 4'hF;
    pulse_imem();
    pulse_dmem();
    steps(300);
    chk("exec_saturated", 32'(exec_cycles), MAXE);
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    chk_reset("async_reset");
    model_reset();
    @(negedge clk);
    rstN = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) startN = ~startN;
      imem_rx_done = ($urandom_range(0, 3) == 0);
      dmem_rx_done = ($urandom_range(0, 3) == 0);
      dmem_tx_done = ($urandom_range(0, 3) == 0);
      reload_imem  = $urandom_range(0, 1) == 1;
      core_mask    = CC'($urandom);
      core_done    = CC'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
